bus_requester: RTL and testbench

BUS_REQUESTER -- requirements
Module: bus_requester

---
 rtl/bus_requester_if.sv | 29 ++
 rtl/bus_requester.sv | 188 ++++++++++++++++++
 tb/tb_bus_requester.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_requester_if.sv
// rtl/bus_requester_if.sv - command, write-data and arbitrated bus signals of bus_requester
`timescale 1ns/1ps
interface bus_requester_if #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4
);
   logic              cmd_valid;
   logic [LEN_W-1:0]  cmd_len;
   logic              cmd_ready;
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              req;
   logic              grant;
   logic              bus_valid;
   logic [DATA_W-1:0] bus_data;

   // requester side: takes commands and payload, requests the bus and drives beats
   modport master (
      input  cmd_valid, cmd_len, wr_valid, wr_data, grant,
      output cmd_ready, wr_ready, req, bus_valid, bus_data
   );

   // command source, payload source and arbiter side
   modport slave (
      output cmd_valid, cmd_len, wr_valid, wr_data, grant,
      input  cmd_ready, wr_ready, req, bus_valid, bus_data
   );
endinterface

// File: rtl/bus_requester.sv
// rtl/bus_requester.sv - bus requester: command FSM, arbiter handshake and write-data FIFO
`timescale 1ns/1ps
module bus_requester #(
   parameter int DATA_W     = 8,
   parameter int LEN_W      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64
)(
   input  logic            i_clock,
   input  logic            i_reset,
   bus_requester_if.master bus,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_err_timeout,
   output logic            o_err_grant_lost
);
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_XFER    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [LEN_W-1:0]    r_beat_cnt;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic                r_req;
   logic                r_done;
   logic                r_err_timeout;
   logic                r_err_grant_lost;

   logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wptr;
   logic [PTR_W-1:0]    r_rptr;
   logic [CNT_W-1:0]    r_count;

   logic                w_accept;
   logic                w_beat;
   logic                w_last;
   logic                w_timeout;
   logic                w_grant_lost;
   logic                w_push;
   logic                w_pop;
   logic                w_empty;
   logic                w_full;
   logic                w_flush;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_push  = bus.wr_valid & ~w_full;
   assign w_pop   = w_beat;
   // The error flags are cleared on accept and only set by error exits, so in
   // RELEASE they identify an abandoned transfer whose leftover payload must go.
   assign w_flush = (r_state == S_RELEASE) & (r_err_timeout | r_err_grant_lost);

   assign bus.cmd_ready  = (r_state == S_IDLE);
   assign bus.wr_ready   = ~w_full;
   assign bus.req        = r_req;
   assign bus.bus_valid  = w_beat;
   assign bus.bus_data   = w_beat ? r_mem[r_rptr] : '0;

   assign o_busy           = (r_state != S_IDLE);
   assign o_done           = r_done;
   assign o_err_timeout    = r_err_timeout;
   assign o_err_grant_lost = r_err_grant_lost;

   // state register
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state decode plus the per-cycle events (accept, beat, exits)
   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_beat       = 1'b0;
      w_last       = 1'b0;
      w_timeout    = 1'b0;
      w_grant_lost = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.grant) begin
               w_state_nxt = S_XFER;
            end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_RELEASE;
            end
         end
         S_XFER: begin
            // losing grant mid-transfer aborts; an empty FIFO with grant simply stalls
            if (!bus.grant) begin
               w_grant_lost = 1'b1;
               w_state_nxt  = S_RELEASE;
            end else if (!w_empty) begin
               w_beat = 1'b1;
               if (r_beat_cnt == '0) begin
                  w_last      = 1'b1;
                  w_state_nxt = S_RELEASE;
               end
            end
         end
         S_RELEASE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // transfer bookkeeping: registered req/done, beat and wait counters, sticky errors
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_req            <= 1'b0;
         r_done           <= 1'b0;
         r_beat_cnt       <= '0;
         r_wait_cnt       <= '0;
         r_err_timeout    <= 1'b0;
         r_err_grant_lost <= 1'b0;
      end else begin
         r_req  <= (w_state_nxt == S_REQ) || (w_state_nxt == S_XFER);
         r_done <= w_last;
         if (w_accept) begin
            r_beat_cnt       <= bus.cmd_len;
            r_wait_cnt       <= '0;
            r_err_timeout    <= 1'b0;
            r_err_grant_lost <= 1'b0;
         end else begin
            if ((r_state == S_REQ) && !bus.grant && !w_timeout) begin
               r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_beat) begin
               r_beat_cnt <= r_beat_cnt - LEN_W'(1);
            end
            if (w_timeout) begin
               r_err_timeout <= 1'b1;
            end
            if (w_grant_lost) begin
               r_err_grant_lost <= 1'b1;
            end
         end
      end
   end

   // FIFO pointers and occupancy; a push into an empty FIFO is only visible next cycle
   always_ff @(posedge i_clock) begin
      if (i_reset || w_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents are don't-care while the occupancy count says empty
   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_mem[r_wptr] <= bus.wr_data;
      end
   end
endmodule

// File: tb/tb_bus_requester.sv
// tb/tb_bus_requester.sv - scoreboard bench for bus_requester
`timescale 1ns/1ps
module tb_bus_requester;
   localparam int DATA_W     = 8;
   localparam int LEN_W      = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int TIMEOUT    = 64;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic busy, done, err_timeout, err_grant_lost;

   bus_requester_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

   bus_requester #(
      .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .i_clock          (clock),
      .i_reset          (reset),
      .bus              (bus),
      .o_busy           (busy),
      .o_done           (done),
      .o_err_timeout    (err_timeout),
      .o_err_grant_lost (err_grant_lost)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;
   logic [DATA_W-1:0] exp_q[$];
   int cyc = 0;
   int beats = 0;
   int req_cyc = 0;
   int done_cnt = 0;
   int beat_cyc [256];
   int b0, r0, d0;
   bit seen;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // bus monitor: counts req/done cycles and checks every beat against the scoreboard
   always @(negedge clock) begin
      cyc++;
      if (bus.req) req_cyc++;
      if (done) done_cnt++;
      if (bus.bus_valid) begin
         if (beats < 256) beat_cyc[beats] = cyc;
         beats++;
         if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
         else chk("beat_data", bus.bus_data, exp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic push_word(input logic [DATA_W-1:0] d, input bit expect_out);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      if (expect_out) exp_q.push_back(d);
      tick();
      bus.wr_valid = 1'b0;
   endtask

   task automatic issue_cmd(input logic [LEN_W-1:0] len);
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = len;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic snap();
      b0 = beats;
      r0 = req_cyc;
      d0 = done_cnt;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         tick();
         if (done) begin
            got = 1'b1;
            chk({tag, "_req_low_at_done"}, bus.req, 0);
         end
      end
      chk({tag, "_done_seen"}, got, 1);
      tick();
      chk({tag, "_back_idle"}, {bus.cmd_ready, busy}, 2'b10);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_req"}, bus.req, 0);
      chk({tag, "_bus_valid"}, bus.bus_valid, 0);
      chk({tag, "_bus_data"}, bus.bus_data, 0);
      chk({tag, "_busy_done"}, {busy, done}, 0);
      chk({tag, "_errs"}, {err_timeout, err_grant_lost}, 0);
      chk({tag, "_readies"}, {bus.cmd_ready, bus.wr_ready}, 2'b11);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_len   = '0;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = '0;
      bus.grant     = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      check_reset_vals("rst");
      reset = 1'b0;
      tick();

      // four beats, grant two cycles after req
      snap();
      for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i), 1'b1);
      issue_cmd(4'd3);
      chk("t1_req_up", bus.req, 1);
      tick();
      tick();
      bus.grant = 1'b1;
      wait_done("t1", 20);
      bus.grant = 1'b0;
      chk("t1_req_cycles", req_cyc - r0, 7);
      chk("t1_beats", beats - b0, 4);
      chk("t1_consecutive", beat_cyc[b0 + 3] - beat_cyc[b0], 3);
      chk("t1_done_count", done_cnt - d0, 1);

      // single beat with grant already high
      bus.grant = 1'b1;
      snap();
      push_word(8'h5A, 1'b1);
      issue_cmd(4'd0);
      wait_done("t2", 10);
      bus.grant = 1'b0;
      chk("t2_req_cycles", req_cyc - r0, 2);
      chk("t2_beats", beats - b0, 1);
      chk("t2_done_count", done_cnt - d0, 1);
      chk("t2_errs", {err_timeout, err_grant_lost}, 0);

      // grant never arrives: timeout, FIFO flushed
      for (int i = 0; i < 4; i++) push_word(8'h10 + 8'(i), 1'b0);
      chk("t3_full", bus.wr_ready, 0);
      snap();
      issue_cmd(4'd3);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         if (err_timeout) seen = 1'b1;
      end
      chk("t3_timeout_seen", seen, 1);
      tick();
      chk("t3_req_cycles", req_cyc - r0, TIMEOUT);
      chk("t3_no_done", done_cnt - d0, 0);
      chk("t3_flushed", bus.wr_ready, 1);
      chk("t3_idle_sticky", {busy, err_timeout}, 2'b01);

      // FIFO runs dry mid-transfer: five stall cycles, req held
      bus.grant = 1'b1;
      snap();
      push_word(8'hB0, 1'b1);
      push_word(8'hB1, 1'b1);
      issue_cmd(4'd3);
      repeat (7) tick();
      push_word(8'hB2, 1'b1);
      push_word(8'hB3, 1'b1);
      wait_done("t4", 10);
      bus.grant = 1'b0;
      chk("t4_beats", beats - b0, 4);
      chk("t4_stall_gap", beat_cyc[b0 + 2] - beat_cyc[b0 + 1], 6);
      chk("t4_req_cycles", req_cyc - r0, 10);
      chk("t4_errs", {err_timeout, err_grant_lost}, 0);

      // FIFO full drops the fifth word; grant lost after two beats
      push_word(8'hC0, 1'b1);
      push_word(8'hC1, 1'b1);
      push_word(8'hC2, 1'b0);
      push_word(8'hC3, 1'b0);
      chk("t5_full", bus.wr_ready, 0);
      push_word(8'hC4, 1'b0);
      snap();
      bus.grant = 1'b1;
      issue_cmd(4'd3);
      repeat (3) tick();
      bus.grant = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         if (err_grant_lost) seen = 1'b1;
      end
      chk("t5_grant_lost_seen", seen, 1);
      chk("t5_req_dropped", bus.req, 0);
      tick();
      chk("t5_beats", beats - b0, 2);
      chk("t5_no_done", done_cnt - d0, 0);
      chk("t5_req_cycles", req_cyc - r0, 4);
      chk("t5_flags", {busy, err_timeout, err_grant_lost}, 3'b001);

      // reset in the middle of a transfer, then a clean transfer
      bus.grant = 1'b1;
      snap();
      push_word(8'hD0, 1'b1);
      push_word(8'hD1, 1'b0);
      issue_cmd(4'd3);
      tick();
      reset = 1'b1;
      tick();
      check_reset_vals("t6_rst");
      reset = 1'b0;
      tick();
      push_word(8'hE7, 1'b1);
      issue_cmd(4'd0);
      wait_done("t6", 10);
      bus.grant = 1'b0;
      chk("t6_beats", beats - b0, 2);
      chk("t6_done_count", done_cnt - d0, 1);

      tick();
      tick();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
